// File: rtl/up_sample.sv
// Integer-factor up-sampler: one input becomes 1/2/4/8 output samples, which are
// zero-stuffed or held. Define UP_SAMPLE_INTERP_EN to build linear interpolation.
module up_sample #(
  parameter int data_width = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_factor,
  input  logic [1:0]            i_mode,
  output logic [data_width-1:0] o_data,
  output logic                  o_valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state_reg;
  logic [2:0]            phase_reg;
  logic [1:0]            l_reg;      // log2 of the latched factor
  logic [1:0]            mode_reg;
  logic [data_width-1:0] cur_reg;
  logic [data_width-1:0] data_reg;
  logic                  valid_reg;

  logic [2:0]            last_phase;
  logic                  accept;
  logic [data_width-1:0] sel_cur;
  logic [1:0]            sel_mode;
  logic [2:0]            sel_phase;
  logic [data_width-1:0] data_next;

  always_comb begin
    last_phase = 3'd0;
    case (l_reg)
      2'd0: last_phase = 3'd0;
      2'd1: last_phase = 3'd1;
      2'd2: last_phase = 3'd3;
      default: last_phase = 3'd7;
    endcase
  end

  assign o_ready = (state_reg == IDLE) || (phase_reg == last_phase);
  assign accept  = i_valid && o_ready;

  // The output register is loaded with the value of the phase about to be shown,
  // so on an accept the fresh sample and settings are used directly.
  assign sel_cur   = accept ? i_data : cur_reg;
  assign sel_mode  = accept ? i_mode : mode_reg;
  assign sel_phase = accept ? 3'd0 : phase_reg + 3'd1;

`ifdef UP_SAMPLE_INTERP_EN
  logic [data_width-1:0]        prev_reg;
  logic [data_width-1:0]        sel_prev;
  logic [1:0]                   sel_l;
  logic signed [data_width:0]   diff;
  logic signed [data_width+3:0] diff_ext;
  logic signed [data_width+3:0] mult;
  logic signed [data_width+3:0] prod;
  logic signed [data_width+3:0] prev_ext;
  logic [3:0]                   k_plus;
  logic [data_width-1:0]        interp_val;

  assign sel_prev = accept ? cur_reg : prev_reg;
  assign sel_l    = accept ? i_factor : l_reg;
  assign k_plus   = {1'b0, sel_phase} + 4'd1;
  assign diff     = $signed({sel_cur[data_width-1], sel_cur}) - $signed({sel_prev[data_width-1], sel_prev});
  assign diff_ext = {{3{diff[data_width]}}, diff};
  assign mult     = $signed({{data_width{1'b0}}, k_plus});
  assign prod     = diff_ext * mult;
  assign prev_ext = $signed({{4{sel_prev[data_width-1]}}, sel_prev});
  // Result lies between prev and cur, so truncation back to data_width is exact.
  assign interp_val = data_width'(prev_ext + (prod >>> sel_l));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_reg <= '0;
    end else if (accept) begin
      prev_reg <= cur_reg;
    end
  end
`endif

  always_comb begin
    data_next = sel_cur;
    case (sel_mode)
      2'b00: data_next = (sel_phase == 3'd0) ? sel_cur : '0;
`ifdef UP_SAMPLE_INTERP_EN
      2'b10: data_next = interp_val;
`endif
      default: data_next = sel_cur;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      phase_reg <= 3'd0;
      l_reg     <= 2'd0;
      mode_reg  <= 2'd0;
      cur_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      state_reg <= RUN;
      phase_reg <= 3'd0;
      l_reg     <= i_factor;
      mode_reg  <= i_mode;
      cur_reg   <= i_data;
      data_reg  <= data_next;
      valid_reg <= 1'b1;
    end else if (state_reg == RUN) begin
      if (phase_reg == last_phase) begin
        state_reg <= IDLE;
        phase_reg <= 3'd0;
        valid_reg <= 1'b0;
      end else begin
        phase_reg <= sel_phase;
        data_reg  <= data_next;
      end
    end
  end

  assign o_data  = data_reg;
  assign o_valid = valid_reg;

endmodule

// File: doc/up_sample.md
Name: up_sample

Overview:
Integer-factor up-sampler (interpolator), the transmit-side counterpart of down_sample.
- Accepts low-rate signed samples through a valid/ready handshake.
- Emits a full-rate stream of 1, 2, 4 or 8 output samples per accepted input.
- Output is zero-stuffed or sample-held. Linear interpolation is an optional build feature.
- Feeds the DAC/filter chain after rate conversion.

Parameters:
data_width, 16, width of signed input and output samples

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_data  input  data_width  signed input sample
i_valid  input  1  i_data valid
o_ready  output  1  block can accept a sample this cycle
i_factor  input  2  rate: 00=x1, 01=x2, 10=x4, 11=x8 (L=1,2,4,8)
i_mode  input  2  00=zero-stuff, 01=hold, 10=interp (macro only), 11=hold
o_data  output  data_width  signed output sample
o_valid  output  1  o_data valid

Behaviour:
- Reset is synchronous and active-high; i_rst is sampled on the i_clk rising edge.
- Reset values: o_data=0, o_valid=0, o_ready=1, phase=0, state=IDLE, cur=0, prev=0.
- Accept: i_valid && o_ready at a rising edge.
  - On accept: prev<=cur, cur<=i_data.
  - i_factor and i_mode are latched as L_r and mode_r. Changes between accepts are ignored until the next accept.
- o_ready is decoded from registers only (no combinational path from i_valid): o_ready = (state==IDLE) || (phase==L_r-1).
- States:
  - IDLE: o_valid=0. o_data holds its last value.
    - Accept -> RUN, phase=0.
  - RUN: o_valid=1, one output per clock. Phase increments each cycle.
    - At phase==L_r-1 with accept -> phase=0, stay in RUN. Back-to-back output, no bubble.
    - At phase==L_r-1 without accept -> IDLE.
- Latency: the first output (phase 0) is registered at the accept edge and visible the following cycle. Exactly L_r o_valid cycles per accepted sample.
- Output value at phase k:
  - zero-stuff: k==0 -> cur; k>0 -> 0.
  - hold: cur for all k.
- L=1: every accept yields one output. o_ready stays 1 in RUN, so continuous i_valid gives continuous o_valid.
- No stall input: the downstream side must accept every o_valid cycle.
- Reset mid-burst: the next cycle shows o_valid=0 and o_ready=1. The remaining phases are discarded.
- i_valid while o_ready=0: not accepted. The upstream must hold i_data/i_valid.
- Phase counter is 3 bits and never exceeds L_r-1; no wrap-around beyond 7.

Optional Feature:
Macro UP_SAMPLE_INTERP_EN.

Defined: i_mode=10 selects linear interpolation.
- At phase k: o_data = prev + (((cur-prev)*(k+1)) >>> log2(L_r)).
- Arithmetic widths:
  - difference is data_width+1 bits;
  - product is data_width+4 bits, signed;
  - arithmetic right shift.
- The result always lies between prev and cur, so it fits data_width with no saturation.
- The last phase equals cur exactly.
- prev is the previously accepted sample (0 after reset).
- In L=1 the output is cur.

Undefined: i_mode=10 behaves as hold. The prev register and multiplier are not built.

Test Plan:
- Assert i_rst for 2 cycles, then release -> o_valid=0, o_data=0, o_ready=1; no outputs while i_valid=0.
- L=x4, zero-stuff, single accept of 100 -> o_valid 4 cycles with o_data 100,0,0,0; o_ready=1 only on the 4th output cycle; then IDLE.
- L=x2, hold, i_valid held high with samples 5,-7 -> contiguous o_valid for 4 cycles with 5,5,-7,-7; the second accept occurs on the phase-1 cycle.
- L=x8, accept 3, switch i_factor to x2 at phase 2 -> eight outputs of 3 (hold); next accepted sample 9 -> exactly two outputs of 9.
- L=x4, accept 50, assert i_rst at phase 1 -> o_valid=0 and o_ready=1 the cycle after reset; the remaining phases are never output.
- With UP_SAMPLE_INTERP_EN, L=x4, interp, after reset accept 100 then -100 -> outputs 25,50,75,100 then 50,0,-50,-100.
